// File: rtl/bpsk_pkg.sv
// Shared constants and state encoding for the BPSK demapper / word packer.
package bpsk_pkg;
    localparam int WORD_BITS      = 128;
    localparam int SAMPLE_W       = 11;
    localparam int THRESH_DEFAULT = 64;
    localparam int CNT_W          = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/bpsk_slicer.sv
// Combinational BPSK hard decision plus low-confidence flag from the in-phase sample.
module bpsk_slicer
    import bpsk_pkg::*;
#(
    parameter int THRESH = THRESH_DEFAULT
) (
    input  logic signed [SAMPLE_W-1:0] xr_i,
    output logic                       bit_o,
    output logic                       lowconf_o
);

    logic [SAMPLE_W-1:0] mag;

    // The most negative code has no positive twin, so it saturates to the largest magnitude.
    always_comb begin
        bit_o = xr_i[SAMPLE_W-1];
        if (xr_i == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (xr_i[SAMPLE_W-1]) begin
            mag = -xr_i;
        end else begin
            mag = xr_i;
        end
        lowconf_o = (32'(mag) < THRESH);
    end

endmodule

// File: rtl/bpsk_demap_pack.sv
// Packs BPSK hard decisions into 128-bit words with a low-confidence count and a one-deep output hold.
module bpsk_demap_pack #(
    parameter int THRESH    = bpsk_pkg::THRESH_DEFAULT,
    parameter int WORD_BITS = bpsk_pkg::WORD_BITS
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 ce,
    input  logic                                 valid_i,
    input  logic signed [bpsk_pkg::SAMPLE_W-1:0] xr,
    input  logic signed [bpsk_pkg::SAMPLE_W-1:0] xi,
    output logic [WORD_BITS-1:0]                 data_o,
    output logic                                 valid_o,
    input  logic                                 ack_i,
    output logic [bpsk_pkg::CNT_W-1:0]           lowconf_o,
    output logic                                 overflow_o,
    output logic [bpsk_pkg::CNT_W-1:0]           bitcnt_o
);
    import bpsk_pkg::*;

    localparam int IDX_W = $clog2(WORD_BITS);

    logic                 accept;
    logic                 sampleBit;
    logic                 sampleLow;
    logic                 wordDone;
    logic [WORD_BITS-1:0] wordData;
    logic [CNT_W-1:0]     wordLow;

    logic [WORD_BITS-1:0] shiftQ, shiftD;
    logic [CNT_W-1:0]     bitcntQ, bitcntD;
    logic [CNT_W-1:0]     partialLowQ, partialLowD;

    state_t               stateQ;
    logic [WORD_BITS-1:0] dataQ;
    logic [CNT_W-1:0]     lowconfQ;
    logic                 overflowQ;

    logic                 unusedXi;
    assign unusedXi = ^xi;

    bpsk_slicer #(
        .THRESH   (THRESH)
    ) uSlicer (
        .xr_i     (xr),
        .bit_o    (sampleBit),
        .lowconf_o(sampleLow)
    );

    assign accept = ce & valid_i;

    // wordData/wordLow always include the current sample so the completing word can load directly.
    always_comb begin
        shiftD      = shiftQ;
        bitcntD     = bitcntQ;
        partialLowD = partialLowQ;
        wordDone    = 1'b0;
        wordData    = shiftQ;
        wordData[bitcntQ[IDX_W-1:0]] = sampleBit;
        wordLow     = partialLowQ + {{(CNT_W-1){1'b0}}, sampleLow};
        if (accept) begin
            if (bitcntQ == CNT_W'(WORD_BITS - 1)) begin
                wordDone    = 1'b1;
                shiftD      = '0;
                bitcntD     = '0;
                partialLowD = '0;
            end else begin
                shiftD      = wordData;
                bitcntD     = bitcntQ + 1'b1;
                partialLowD = wordLow;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            shiftQ      <= '0;
            bitcntQ     <= '0;
            partialLowQ <= '0;
        end else begin
            shiftQ      <= shiftD;
            bitcntQ     <= bitcntD;
            partialLowQ <= partialLowD;
        end
    end

    // Output hold: a word completing while the previous one is still unacknowledged is dropped.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            stateQ    <= EMPTY;
            dataQ     <= '0;
            lowconfQ  <= '0;
            overflowQ <= 1'b0;
        end else begin
            case (stateQ)
                EMPTY: begin
                    if (wordDone) begin
                        dataQ    <= wordData;
                        lowconfQ <= wordLow;
                        stateQ   <= FULL;
                    end
                end
                FULL: begin
                    if (wordDone && ack_i) begin
                        dataQ    <= wordData;
                        lowconfQ <= wordLow;
                    end else if (wordDone) begin
                        overflowQ <= 1'b1;
                    end else if (ack_i) begin
                        stateQ <= EMPTY;
                    end
                end
                default: stateQ <= EMPTY;
            endcase
        end
    end

    assign data_o     = dataQ;
    assign valid_o    = (stateQ == FULL);
    assign lowconf_o  = lowconfQ;
    assign overflow_o = overflowQ;
    assign bitcnt_o   = bitcntQ;

endmodule

// File: tb/tb_bpsk_demap_pack.sv
// Self-checking bench: a queue-based word model checked every cycle, plus directed literal scenarios.
module tb_bpsk_demap_pack;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic               ce = 1'b0;
    logic               valid_i = 1'b0;
    logic signed [10:0] xr = '0;
    logic signed [10:0] xi = '0;
    logic               ack_i = 1'b0;
    logic [127:0]       data_o;
    logic               valid_o;
    logic [7:0]         lowconf_o;
    logic               overflow_o;
    logic [7:0]         bitcnt_o;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    logic [127:0] mData;
    bit           mValid;
    int           mLowOut;
    bit           mOverflow;
    bit           mBits[$];
    bit           mLows[$];

    bpsk_demap_pack dut (
        .CLK       (CLK),
        .RST       (RST),
        .ce        (ce),
        .valid_i   (valid_i),
        .xr        (xr),
        .xi        (xi),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ack_i     (ack_i),
        .lowconf_o (lowconf_o),
        .overflow_o(overflow_o),
        .bitcnt_o  (bitcnt_o)
    );

    always #5 CLK = ~CLK;

    function automatic bit modelBit(int x);
        return x < 0;
    endfunction

    function automatic bit modelLow(int x);
        int m;
        m = (x < 0) ? -x : x;
        if (m > 1023) m = 1023;
        return m < 64;
    endfunction

    task automatic checkOutput(string name, logic [127:0] actual, logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: accepted samples accumulate in queues; a full queue becomes one word offered to the hold.
    always @(posedge CLK) begin
        bit           done;
        logic [127:0] w;
        int           lc;
        done = 1'b0;
        w    = '0;
        lc   = 0;
        if (!RST) begin
            mData     = '0;
            mValid    = 1'b0;
            mLowOut   = 0;
            mOverflow = 1'b0;
            mBits.delete();
            mLows.delete();
        end else begin
            if (ce && valid_i) begin
                mBits.push_back(modelBit(int'(xr)));
                mLows.push_back(modelLow(int'(xr)));
                if (mBits.size() == 128) begin
                    foreach (mBits[i]) begin
                        w[i] = mBits[i];
                        lc  += int'(mLows[i]);
                    end
                    done = 1'b1;
                    mBits.delete();
                    mLows.delete();
                end
            end
            if (done) begin
                if (!mValid || ack_i) begin
                    mData   = w;
                    mLowOut = lc;
                    mValid  = 1'b1;
                end else begin
                    mOverflow = 1'b1;
                end
            end else if (mValid && ack_i) begin
                mValid = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("model data_o", data_o, mData);
            checkOutput("model valid_o", 128'(valid_o), 128'(mValid));
            checkOutput("model lowconf_o", 128'(lowconf_o), 128'(mLowOut));
            checkOutput("model overflow_o", 128'(overflow_o), 128'(mOverflow));
            checkOutput("model bitcnt_o", 128'(bitcnt_o), 128'(mBits.size()));
        end
    end

    task automatic applyStimulus(input int x, input logic c, input logic v, input logic a);
        xr      = 11'(x);
        xi      = 11'($urandom_range(0, 2047));
        ce      = c;
        valid_i = v;
        ack_i   = a;
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset(input int cycles);
        RST = 1'b0;
        repeat (cycles) applyStimulus(0, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
    endtask

    function automatic int randSample();
        case ($urandom_range(0, 5))
            0:       return -1024;
            1:       return 0;
            2:       return int'($urandom_range(0, 127)) - 64;
            default: return int'($urandom_range(0, 2047)) - 1024;
        endcase
    endfunction

    initial begin
        int           rises;
        logic         prevValid;
        logic [127:0] expWord;
        int           s;
        int           k;

        doReset(2);
        checkEn = 1'b1;
        checkOutput("reset data_o", data_o, 128'd0);
        checkOutput("reset valid_o", 128'(valid_o), 128'd0);
        checkOutput("reset bitcnt_o", 128'(bitcnt_o), 128'd0);
        checkOutput("reset overflow_o", 128'(overflow_o), 128'd0);

        for (int i = 0; i < 128; i++) applyStimulus((i % 2 == 0) ? 1 : -1, 1'b1, 1'b1, 1'b0);
        checkOutput("alt data_o", data_o, {32{4'hA}});
        checkOutput("alt valid_o", 128'(valid_o), 128'd1);
        checkOutput("alt lowconf_o", 128'(lowconf_o), 128'd128);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        checkOutput("ack valid_o", 128'(valid_o), 128'd0);

        for (int i = 0; i < 128; i++) begin
            s = (i == 0) ? 0 : (i == 1) ? -1024 : (i == 2) ? 63 : 200;
            applyStimulus(s, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("edge bits", 128'(data_o[2:0]), 128'd2);
        checkOutput("edge lowconf_o", 128'(lowconf_o), 128'd2);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 128; i++) applyStimulus(500, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 128; i++) applyStimulus(-500, 1'b1, 1'b1, 1'b0);
        checkOutput("ovf data_o", data_o, 128'd0);
        checkOutput("ovf overflow_o", 128'(overflow_o), 128'd1);
        checkOutput("ovf lowconf_o", 128'(lowconf_o), 128'd0);
        checkOutput("ovf valid_o", 128'(valid_o), 128'd1);

        doReset(1);
        for (int i = 0; i < 128; i++) applyStimulus(500, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 128; i++) applyStimulus(-300, 1'b1, 1'b1, (i == 127) ? 1'b1 : 1'b0);
        checkOutput("ackdone data_o", data_o, {128{1'b1}});
        checkOutput("ackdone valid_o", 128'(valid_o), 128'd1);
        checkOutput("ackdone overflow_o", 128'(overflow_o), 128'd0);

        for (int i = 0; i < 50; i++) applyStimulus(randSample(), 1'b1, 1'b1, 1'b0);
        doReset(1);
        for (int i = 0; i < 128; i++) applyStimulus(-100, 1'b1, 1'b1, 1'b0);
        checkOutput("midreset data_o", data_o, {128{1'b1}});
        checkOutput("midreset bitcnt_o", 128'(bitcnt_o), 128'd0);
        checkOutput("midreset lowconf_o", 128'(lowconf_o), 128'd0);

        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        rises     = 0;
        prevValid = valid_o;
        expWord   = '0;
        k         = 0;
        for (int i = 0; i < 256; i++) begin
            s = randSample();
            if (i % 2 == 0) begin
                expWord[k] = (s < 0);
                k++;
            end
            applyStimulus(s, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            if (valid_o && !prevValid) rises++;
            prevValid = valid_o;
        end
        checkOutput("ce words", 128'(rises), 128'd1);
        checkOutput("ce data_o", data_o, expWord);
        checkOutput("ce bitcnt_o", 128'(bitcnt_o), 128'd0);

        for (int i = 0; i < 4000; i++) begin
            RST = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            applyStimulus(randSample(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 15) == 0));
        end
        RST = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
